// File: rtl/float_acc_12.sv
// Accumulates a run of 12-bit floats (1s|5e bias 15|6m) into one sum, one term per cycle while ready_o.
// sum_valid_o pulses one cycle after the last accepted term; inputs arriving outside a run are dropped.
module float_acc_12 #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [11:0]      data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [11:0]      sum_o,
    output logic             sum_valid_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [11:0]       acc_q;
    logic [11:0]       acc_d;
    logic [11:0]       sum_q;
    logic              ready_q;
    logic              sum_valid_q;
    logic              busy_q;

    logic [11:0]       x;
    logic [11:0]       y;
    logic [4:0]        d;
    logic [7:0]        ma;
    logic [7:0]        mb;
    logic [8:0]        s;
    logic [7:0]        n;
    logic [7:0]        r;
    logic [3:0]        lz;
    logic              found;
    logic signed [7:0] e;
    logic [5:0]        m;

    always_comb begin
        x     = acc_q;
        y     = data_i;
        d     = 5'd0;
        ma    = 8'd0;
        mb    = 8'd0;
        s     = 9'd0;
        n     = 8'd0;
        r     = 8'd0;
        lz    = 4'd0;
        found = 1'b0;
        e     = 8'sd0;
        m     = 6'd0;
        acc_d = acc_q;
        cnt_d = cnt_q + 1'b1;
        if (acc_q[10:6] == 5'd0) begin
            acc_d = data_i;
        end else if (data_i[10:6] == 5'd0) begin
            acc_d = acc_q;
        end else begin
            if (data_i[10:0] > acc_q[10:0]) begin
                x = data_i;
                y = acc_q;
            end
            d  = x[10:6] - y[10:6];
            ma = {1'b1, x[5:0], 1'b0};
            mb = (d >= 5'd8) ? 8'd0 : ({1'b1, y[5:0], 1'b0} >> d);
            s  = (x[11] == y[11]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
            for (int i = 7; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz = lz + 4'd1;
                end
            end
            e = $signed({3'b000, x[10:6]});
            if (s[8]) begin
                n = s[8:1];
                e = e + 8'sd1;
            end else begin
                n = s[7:0] << lz;
                e = e - $signed({4'b0000, lz});
            end
            // n holds {hidden, 6 mantissa bits, guard}; round half-up on the guard bit
            r = {1'b0, n[7:1]} + {7'd0, n[0]};
            if (r[7]) begin
                m = r[6:1];
                e = e + 8'sd1;
            end else begin
                m = r[5:0];
            end
            if (s == 9'd0)          acc_d = 12'h000;
            else if (e > 8'sd31)    acc_d = {x[11], 11'h7FF};
            else if (e <= 8'sd0)    acc_d = 12'h000;
            else                    acc_d = {x[11], e[4:0], m};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= 12'h000;
            sum_q       <= 12'h000;
            ready_q     <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q  <= len_i;
                        cnt_q  <= '0;
                        acc_q  <= 12'h000;
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q <= ACC;
                            ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            sum_q       <= 12'h000;
                            sum_valid_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (valid_i) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q     <= DONE;
                            ready_q     <= 1'b0;
                            sum_q       <= acc_d;
                            sum_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sum_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_float_acc_12.sv
// Bench for float_acc_12: directed runs with literal sums, then random traffic against a run-level model.
module tb_float_acc_12;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = 8'd0;
    logic [11:0] data_i = 12'h000;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [11:0] sum_o;
    logic        sum_valid_o;
    logic        busy_o;

    int n_chk = 0;
    int n_err = 0;

    float_acc_12 #(.CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .sum_o(sum_o),
        .sum_valid_o(sum_valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference sum from the number rules, using integer magnitudes in guard-bit units.
    function automatic logic [11:0] fadd(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] x, y;
        longint magA, magB;
        int ex, d, t, e;
        if (a[10:6] == 5'd0) return b;
        if (b[10:6] == 5'd0) return a;
        magA = longint'(64 + a[5:0]) << a[10:6];
        magB = longint'(64 + b[5:0]) << b[10:6];
        if (magA >= magB) begin x = a; y = b; end
        else              begin x = b; y = a; end
        ex = x[10:6];
        d  = ex - int'(y[10:6]);
        t  = (x[11] == y[11]) ? ((64 + x[5:0]) * 2 + (((64 + y[5:0]) * 2) >> d))
                              : ((64 + x[5:0]) * 2 - (((64 + y[5:0]) * 2) >> d));
        if (t == 0) return 12'h000;
        e = ex;
        while (t >= 256) begin t = t / 2; e++; end
        while (t < 128)  begin t = t * 2; e--; end
        t = (t + 1) / 2;
        if (t == 128) begin t = 64; e++; end
        if (e > 31) return {x[11], 11'h7FF};
        if (e <= 0) return 12'h000;
        return {x[11], 5'(e), 6'(t - 64)};
    endfunction

    // Run-level model: phase 0 = waiting for start, 1 = taking terms, 2 = reporting the sum.
    int          ph = 0;
    int          rem = 0;
    logic [11:0] m_acc = 12'h000;
    logic [11:0] m_sum = 12'h000;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph = 0; m_acc = 12'h000; m_sum = 12'h000;
        end else begin
            case (ph)
                0: if (start_i) begin
                    m_acc = 12'h000;
                    if (len_i == 8'd0) begin m_sum = 12'h000; ph = 2; end
                    else begin rem = int'(len_i); ph = 1; end
                end
                1: if (valid_i) begin
                    m_acc = fadd(m_acc, data_i);
                    rem--;
                    if (rem == 0) begin m_sum = m_acc; ph = 2; end
                end
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        chk("ready_o", {11'd0, ready_o}, {11'd0, ph == 1});
        chk("busy_o", {11'd0, busy_o}, {11'd0, ph != 0});
        chk("sum_valid_o", {11'd0, sum_valid_o}, {11'd0, ph == 2});
        chk("sum_o", sum_o, m_sum);
    end

    task automatic run(input int n, input logic [47:0] tv, input bit gap,
                       input logic [11:0] exp, input string nm);
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = 8'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                valid_i = 1'b0; start_i = 1'b1; len_i = 8'd1;
                @(posedge clk_i); #1;
                start_i = 1'b0;
            end
            valid_i = 1'b1; data_i = tv[i*12 +: 12];
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        chk({nm, " pulse"}, {11'd0, sum_valid_o}, 12'd1);
        chk({nm, " sum"}, sum_o, exp);
        @(negedge clk_i);
        chk({nm, " pulse end"}, {11'd0, sum_valid_o}, 12'd0);
        chk({nm, " sum hold"}, sum_o, exp);
    endtask

    function automatic logic [11:0] rnd_term();
        logic [11:0] v;
        v = {1'($urandom), 5'($urandom_range(13, 19)), 6'($urandom)};
        case ($urandom_range(0, 9))
            0:       v = 12'h000;
            1:       v = {1'($urandom), 5'd31, 6'($urandom)};
            2:       v = {1'($urandom), 5'($urandom_range(1, 4)), 6'($urandom)};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        chk("model 1+1", fadd(12'h3C0, 12'h3C0), 12'h400);
        chk("model 2+1", fadd(12'h400, 12'h3C0), 12'h420);
        chk("model 1.5+1.5", fadd(12'h3E0, 12'h3E0), 12'h420);
        chk("model cancel", fadd(12'h3C0, 12'hBC0), 12'h000);
        chk("model d=8", fadd(12'h3C0, 12'h1C0), 12'h3C0);
        chk("model zero+x", fadd(12'h000, 12'hBE0), 12'hBE0);
        chk("model sat+", fadd(12'h7FF, 12'h7FF), 12'h7FF);
        chk("model sat-", fadd(12'hFFF, 12'hFFF), 12'hFFF);

        #2 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("reset sum_o", sum_o, 12'h000);
        chk("reset ready_o", {11'd0, ready_o}, 12'd0);
        chk("reset busy_o", {11'd0, busy_o}, 12'd0);
        chk("reset sum_valid_o", {11'd0, sum_valid_o}, 12'd0);

        run(3, {12'h000, 12'h3C0, 12'h3C0, 12'h3C0}, 1'b0, 12'h420, "1+1+1");
        run(2, {24'h0, 12'hBC0, 12'h3C0}, 1'b0, 12'h000, "cancel");
        run(2, {24'h0, 12'h3E0, 12'h3E0}, 1'b0, 12'h420, "1.5+1.5");
        run(2, {24'h0, 12'h1C0, 12'h3C0}, 1'b0, 12'h3C0, "d=8");
        run(2, {24'h0, 12'hBE0, 12'h000}, 1'b0, 12'hBE0, "zero+x");
        run(2, {24'h0, 12'h7FF, 12'h7FF}, 1'b0, 12'h7FF, "sat pos");
        run(2, {24'h0, 12'hFFF, 12'hFFF}, 1'b0, 12'hFFF, "sat neg");
        run(0, 48'h0, 1'b0, 12'h000, "len0");

        // terms offered while idle must be dropped
        @(posedge clk_i); #1;
        valid_i = 1'b1; data_i = 12'h7C0;
        repeat (3) @(posedge clk_i);
        #1 valid_i = 1'b0;
        run(3, {12'h000, 12'h3C0, 12'h3C0, 12'h3C0}, 1'b1, 12'h420, "gaps");

        // reset after two of four terms: no pulse, outputs cleared at once
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = 8'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0; valid_i = 1'b1; data_i = 12'h3C0;
        repeat (2) @(posedge clk_i);
        #1 valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst busy_o", {11'd0, busy_o}, 12'd0);
        chk("midrst ready_o", {11'd0, ready_o}, 12'd0);
        chk("midrst sum_valid_o", {11'd0, sum_valid_o}, 12'd0);
        chk("midrst sum_o", sum_o, 12'h000);
        @(posedge clk_i); #1 rst_i = 1'b0;
        run(1, {36'h0, 12'h400}, 1'b0, 12'h400, "after reset");

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            start_i = ($urandom_range(0, 3) == 0);
            len_i   = 8'($urandom_range(0, 6));
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = rnd_term();
        end
        start_i = 1'b0; valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
